// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: sync 1101, 3-bit length N, then N+1 payload bits MSB first.
// Optional even-parity trailer bit when SERIAL_FRAME_TX_PARITY_EN is defined.
module serial_frame_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] len,
  input  logic [7:0] data,
  output logic       serOut,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SYNC    = 3'd1;
  localparam logic [2:0] S_LEN     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam logic [2:0] S_PARITY  = 3'd4;
`endif
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [3:0] SYNC_PAT  = 4'b1101;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [2:0] cnt;
  logic [2:0] cnt_nxt;
  logic [2:0] len_q;
  logic [7:0] data_q;
  logic       ser_nxt;
  logic       busy_nxt;
  logic       done_nxt;

`ifdef SERIAL_FRAME_TX_PARITY_EN
  // Even parity over data[n:0]; bits above n are masked off.
  function automatic logic payload_parity(input logic [2:0] n, input logic [7:0] d);
    logic [7:0] mask;
    mask = 8'hFF >> (3'd7 - n);
    return ^(d & mask);
  endfunction
`endif

  // Bit that belongs on the line while the machine sits in (st, c).
  function automatic logic frame_bit(input logic [2:0] st, input logic [2:0] c,
                                     input logic [2:0] n, input logic [7:0] d);
    logic [1:0] sync_idx;
    logic [1:0] len_idx;
    logic [2:0] pay_idx;
    logic       b;
    sync_idx = 2'd3 - c[1:0];
    len_idx  = 2'd2 - c[1:0];
    pay_idx  = n - c;
    b        = 1'b0;
    case (st)
      S_SYNC:    b = SYNC_PAT[sync_idx];
      S_LEN:     b = n[len_idx];
      S_PAYLOAD: b = d[pay_idx];
`ifdef SERIAL_FRAME_TX_PARITY_EN
      S_PARITY:  b = payload_parity(n, d);
`endif
      default:   b = 1'b0;
    endcase
    return b;
  endfunction

  always_comb begin
    state_nxt = S_IDLE;
    cnt_nxt   = 3'd0;
    case (state)
      S_IDLE: begin
        state_nxt = start ? S_SYNC : S_IDLE;
      end
      S_SYNC: begin
        if (cnt == 3'd3) begin
          state_nxt = S_LEN;
        end else begin
          state_nxt = S_SYNC;
          cnt_nxt   = cnt + 3'd1;
        end
      end
      S_LEN: begin
        if (cnt == 3'd2) begin
          state_nxt = S_PAYLOAD;
        end else begin
          state_nxt = S_LEN;
          cnt_nxt   = cnt + 3'd1;
        end
      end
      S_PAYLOAD: begin
        if (cnt == len_q) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_DONE;
`endif
        end else begin
          state_nxt = S_PAYLOAD;
          cnt_nxt   = cnt + 3'd1;
        end
      end
`ifdef SERIAL_FRAME_TX_PARITY_EN
      S_PARITY: begin
        state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    ser_nxt  = frame_bit(state_nxt, cnt_nxt, len_q, data_q);
    busy_nxt = (state_nxt == S_SYNC) || (state_nxt == S_LEN) || (state_nxt == S_PAYLOAD)
`ifdef SERIAL_FRAME_TX_PARITY_EN
               || (state_nxt == S_PARITY)
`endif
               ;
    done_nxt = (state_nxt == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 3'd0;
      serOut <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      serOut <= ser_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

  // Frame contents are captured once at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && start) begin
      len_q  <= len;
      data_q <= data;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Randomized and directed bench for serial_frame_tx against a bit-list frame model.
// Honors SERIAL_FRAME_TX_PARITY_EN the same way as the design.
module tb_serial_frame_tx;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] len;
  logic [7:0] data;
  logic       serOut;
  logic       busy;
  logic       done;

  int vectors     = 0;
  int miscompares = 0;
  bit exp_q[$];

  serial_frame_tx dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .len    (len),
    .data   (data),
    .serOut (serOut),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference frame as a plain list of bits.
  task automatic build_frame(input int n, input int d);
    int par;
    exp_q.delete();
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    for (int i = 2; i >= 0; i--) exp_q.push_back(bit'((n >> i) & 1));
    par = 0;
    for (int i = n; i >= 0; i--) begin
      exp_q.push_back(bit'((d >> i) & 1));
      par = par ^ ((d >> i) & 1);
    end
`ifdef SERIAL_FRAME_TX_PARITY_EN
    exp_q.push_back(bit'(par));
`endif
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ser"},  serOut, 1'b0);
    check({tag, "_busy"}, busy,   1'b0);
    check({tag, "_done"}, done,   1'b0);
  endtask

  // Called at a negedge while the DUT is in IDLE; returns at the negedge of the
  // following IDLE cycle. hold keeps start high; otherwise start/len/data are
  // scrambled during the frame.
  task automatic run_frame(input string tag, input logic [2:0] n, input logic [7:0] d,
                           input bit hold);
    build_frame(int'(n), int'(d));
    start = 1'b1;
    len   = n;
    data  = d;
    foreach (exp_q[i]) begin
      @(negedge clk);
      check({tag, "_bit"},  serOut, exp_q[i]);
      check({tag, "_busy"}, busy,   1'b1);
      check({tag, "_done"}, done,   1'b0);
      start = hold ? 1'b1 : 1'($urandom_range(0, 1));
      len   = 3'($urandom);
      data  = 8'($urandom);
    end
    @(negedge clk);
    check({tag, "_dser"},  serOut, 1'b0);
    check({tag, "_dbusy"}, busy,   1'b0);
    check({tag, "_dpulse"}, done,  1'b1);
    start = hold ? 1'b1 : 1'($urandom_range(0, 1));
    @(negedge clk);
    check_idle({tag, "_gap"});
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    len   = 3'd0;
    data  = 8'd0;
    #2 rst = 1'b1;
    #1 check_idle("rst_async");
    repeat (2) @(negedge clk);
    check_idle("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    check_idle("idle_start0");
    @(negedge clk);
    check_idle("idle_start0b");

    run_frame("len0_01", 3'd0, 8'h01, 1'b0);
    run_frame("len7_a5", 3'd7, 8'hA5, 1'b0);
    run_frame("len2_05", 3'd2, 8'h05, 1'b0);

    // Back-to-back frames with start held high.
    for (int k = 0; k < 3; k++) run_frame("hold_02", 3'd1, 8'h02, 1'b1);
    start = 1'b0;
    @(negedge clk);
    check_idle("after_hold");

    // Abort during the third payload bit.
    build_frame(5, 8'h6B);
    start = 1'b1;
    len   = 3'd5;
    data  = 8'h6B;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort_bit", serOut, exp_q[i]);
      check("abort_busy", busy, 1'b1);
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1 check_idle("abort_async");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("abort_nodone");
    end
    run_frame("post_abort", 3'd5, 8'h6B, 1'b0);

    for (int k = 0; k < 40; k++) begin
      run_frame("rand", 3'($urandom), 8'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check_idle("rand_idle");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
